// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states
// and the size-to-byte-count helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    function automatic logic [3:0] size_bytes(size_t s);
        return 4'd1 << s;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: extracts and extends load data from
// a doubleword, and merges right-justified store data into a doubleword.
// Ports: word/offset/size/isUnsigned/storeData in; loadValue/storeWord out.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  offset,
    input  size_t       size,
    input  logic        isUnsigned,
    input  logic [63:0] storeData,
    output logic [63:0] loadValue,
    output logic [63:0] storeWord
);

    logic [63:0] shifted;
    logic [63:0] placed;
    logic [63:0] bitMask;
    logic [7:0]  baseMask;
    logic [7:0]  laneMask;

    assign shifted = word >> {offset, 3'b000};
    assign placed  = storeData << {offset, 3'b000};

    always_comb begin
        loadValue = word;
        baseMask  = 8'hFF;
        unique case (size)
            SZ_B: begin
                baseMask  = 8'h01;
                loadValue = isUnsigned ? {56'd0, shifted[7:0]}
                                       : {{56{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                baseMask  = 8'h03;
                loadValue = isUnsigned ? {48'd0, shifted[15:0]}
                                       : {{48{shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                baseMask  = 8'h0F;
                loadValue = isUnsigned ? {32'd0, shifted[31:0]}
                                       : {{32{shifted[31]}}, shifted[31:0]};
            end
            SZ_D: begin
                baseMask  = 8'hFF;
                loadValue = word;
            end
        endcase
    end

    // offset is always size-aligned here, so the shifted mask never wraps
    assign laneMask = baseMask << offset;

    always_comb begin
        bitMask = '0;
        for (int i = 0; i < 8; i++) begin
            bitMask[i*8 +: 8] = {8{laneMask[i]}};
        end
    end

    assign storeWord = (word & ~bitMask) | (placed & bitMask);

endmodule

// File: rtl/load_store_unit.sv
// Data-side load/store unit in front of a 64-bit doubleword memory; does
// lane extraction on loads and read-modify-write for sub-doubleword stores.
// Ports: req_* request handshake, rsp_* one-cycle completion, mem_* memory.
// Optional MISALIGN_TRAP_EN: misaligned accesses return rsp_err with no
// memory traffic; otherwise the offset is forced to the size boundary.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic              mem_wr,
    input  logic [63:0]       mem_rdata
);

    lsu_state_t        state;
    logic [2:0]        cnt;
    logic              weQ;
    size_t             sizeQ;
    logic              unsQ;
    logic [ADDR_W-1:0] addrQ;
    logic [63:0]       wdataQ;
    logic [63:0]       dataQ;
    logic [63:0]       rdataQ;
    logic [2:0]        alignOff;
    logic [63:0]       alignWord;
    logic [63:0]       loadValue;
    logic [63:0]       storeWord;

`ifdef MISALIGN_TRAP_EN
    logic errQ;
    logic misIn;
    assign misIn = (req_addr[2:0]
                   & 3'(size_bytes(size_t'(req_size)) - 4'd1)) != 3'd0;
`endif

    // Misaligned accesses never reach the lanes when trapping, so the
    // mask is a no-op there and the aligning fallback otherwise.
    assign alignOff = addrQ[2:0] & ~3'(size_bytes(sizeQ) - 4'd1);

    // Loads extend straight from the memory bus in the capture cycle;
    // stores merge into the word captured during WAIT.
    assign alignWord = (state == WAIT) ? mem_rdata : dataQ;

    lsu_lane_align uAlign (
        .word       (alignWord),
        .offset     (alignOff),
        .size       (sizeQ),
        .isUnsigned (unsQ),
        .storeData  (wdataQ),
        .loadValue  (loadValue),
        .storeWord  (storeWord)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            weQ    <= 1'b0;
            sizeQ  <= SZ_B;
            unsQ   <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            dataQ  <= '0;
            rdataQ <= '0;
`ifdef MISALIGN_TRAP_EN
            errQ   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        weQ    <= req_we;
                        sizeQ  <= size_t'(req_size);
                        unsQ   <= req_unsigned;
                        addrQ  <= req_addr;
                        wdataQ <= req_wdata;
`ifdef MISALIGN_TRAP_EN
                        if (misIn) begin
                            state  <= RESP;
                            rdataQ <= '0;
                            errQ   <= 1'b1;
                        end else
`endif
                        if (req_we && req_size == 2'd3) begin
                            state <= WRITE;
                        end else begin
                            state <= WAIT;
                            cnt   <= 3'(MEM_LAT);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 3'd1) begin
                        dataQ <= mem_rdata;
                        if (weQ) begin
                            state <= WRITE;
                        end else begin
                            state  <= RESP;
                            rdataQ <= loadValue;
`ifdef MISALIGN_TRAP_EN
                            errQ   <= 1'b0;
`endif
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                WRITE: begin
                    state  <= RESP;
                    rdataQ <= '0;
`ifdef MISALIGN_TRAP_EN
                    errQ   <= 1'b0;
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign mem_wr    = (state == WRITE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdataQ;
    assign mem_addr  = {addrQ[ADDR_W-1:3], 3'b000};
    assign mem_wdata = storeWord;

`ifdef MISALIGN_TRAP_EN
    assign rsp_err = errQ;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: two units (MEM_LAT 1 and 3) on shared request
// fields with private memories; a scoreboard checks every response.
module tb_load_store_unit;

    typedef struct {
        logic [63:0] rd;
        logic        err;
        int          lat;
        time         tAcc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] rd;
        int          lat;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        initMem = 1'b1;
    logic        validA = 1'b0, validB = 1'b0;
    logic        reqWe = 1'b0;
    logic [1:0]  reqSize = 2'd0;
    logic        reqUns = 1'b0;
    logic [63:0] reqAddr = '0;
    logic [63:0] reqWdata = '0;

    logic        readyA, rspValidA, rspErrA, memWrA;
    logic [63:0] rspRdA, memAddrA, memWdA, memRdA;
    logic        readyB, rspValidB, rspErrB, memWrB;
    logic [63:0] rspRdB, memAddrB, memWdB, memRdB;

    logic [63:0] memA [32];
    logic [63:0] memB [32];
    logic [63:0] p1, p2;

    int checks = 0;
    int errors = 0;
    int wrCntA = 0, wrCntB = 0;
    logic [63:0] lastAddrA, lastWdA, lastAddrB, lastWdB;
    exp_t qA[$];
    exp_t qB[$];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_LAT(1), .ADDR_W(64)) dutA (
        .clk(clk), .reset(reset),
        .req_valid(validA), .req_ready(readyA),
        .req_we(reqWe), .req_size(reqSize), .req_unsigned(reqUns),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspValidA), .rsp_rdata(rspRdA), .rsp_err(rspErrA),
        .mem_addr(memAddrA), .mem_wdata(memWdA), .mem_wr(memWrA),
        .mem_rdata(memRdA)
    );

    load_store_unit #(.MEM_LAT(3), .ADDR_W(64)) dutB (
        .clk(clk), .reset(reset),
        .req_valid(validB), .req_ready(readyB),
        .req_we(reqWe), .req_size(reqSize), .req_unsigned(reqUns),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspValidB), .rsp_rdata(rspRdB), .rsp_err(rspErrB),
        .mem_addr(memAddrB), .mem_wdata(memWdB), .mem_wr(memWrB),
        .mem_rdata(memRdB)
    );

    always @(posedge clk) begin
        if (initMem) begin
            for (int i = 0; i < 32; i++) memA[i] <= '0;
            memA[8] <= 64'hF0E1D2C3B4A59687;
        end else if (memWrA) begin
            memA[memAddrA[7:3]] <= memWdA;
        end
    end
    assign memRdA = memA[memAddrA[7:3]];

    always @(posedge clk) begin
        if (initMem) begin
            for (int i = 0; i < 32; i++) memB[i] <= '0;
            memB[8] <= 64'hF0E1D2C3B4A59687;
        end else if (memWrB) begin
            memB[memAddrB[7:3]] <= memWdB;
        end
        p1 <= memB[memAddrB[7:3]];
        p2 <= p1;
    end
    assign memRdB = p2;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkRsp(input string who, input exp_t e,
                            input logic [63:0] rd, input logic er);
        int lat;
        lat = int'(($time - e.tAcc + 5) / 10);
        chk({who, "_rdata"}, rd, e.rd);
        chk({who, "_err"}, 64'(er), 64'(e.err));
        chk({who, "_lat"}, 64'(lat), 64'(e.lat));
    endtask

    task automatic noRsp(input string who);
        checks++;
        errors++;
        $error("FAIL %s_unexpected_rsp: got rsp_valid 1, expected 0", who);
    endtask

    task automatic waitDone();
        for (int i = 0; i < 60; i++) begin
            if (qA.size() == 0 && qB.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        assert (qA.size() == 0 && qB.size() == 0) else begin
            errors++;
            $error("FAIL timeout: got %0d/%0d pending, expected 0",
                   qA.size(), qB.size());
        end
        qA.delete();
        qB.delete();
    endtask

    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd,
                         input logic err, input int latA, input int latB);
        exp_t e;
        @(negedge clk);
        reqWe = we; reqSize = sz; reqUns = uns;
        reqAddr = addr; reqWdata = wd;
        validA = 1'b1; validB = 1'b1;
        @(posedge clk);
        e.rd = rd; e.err = err; e.tAcc = $time;
        e.lat = latA; qA.push_back(e);
        e.lat = latB; qB.push_back(e);
        #1;
        validA = 1'b0; validB = 1'b0;
        waitDone();
    endtask

    initial begin
        int wa, wb;
        exp_t e;
        req_t s[5];

        fork
            forever begin
                @(negedge clk);
                if (rspValidA) begin
                    if (qA.size() == 0) noRsp("A");
                    else begin
                        e = qA.pop_front();
                        checkRsp("A", e, rspRdA, rspErrA);
                    end
                end
                if (rspValidB) begin
                    if (qB.size() == 0) noRsp("B");
                    else begin
                        e = qB.pop_front();
                        checkRsp("B", e, rspRdB, rspErrB);
                    end
                end
                if (memWrA) begin
                    wrCntA++; lastAddrA = memAddrA; lastWdA = memWdA;
                end
                if (memWrB) begin
                    wrCntB++; lastAddrB = memAddrB; lastWdB = memWdB;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_readyA", 64'(readyA), 64'd1);
        chk("rst_readyB", 64'(readyB), 64'd1);
        chk("rst_rspValid", 64'(rspValidA), 64'd0);
        chk("rst_rdata", rspRdA, 64'd0);
        chk("rst_err", 64'(rspErrA), 64'd0);
        chk("rst_memWr", 64'(memWrA), 64'd0);
        chk("rst_memAddr", memAddrA, 64'd0);
        chk("rst_memWdata", memWdA, 64'd0);
        initMem = 1'b0;
        reset = 1'b0;

        issue(0, 2'd0, 0, 64'h40, 0, 64'hFFFFFFFFFFFFFF87, 0, 2, 4);
        issue(0, 2'd0, 1, 64'h40, 0, 64'h0000000000000087, 0, 2, 4);
        issue(0, 2'd1, 0, 64'h46, 0, 64'hFFFFFFFFFFFFF0E1, 0, 2, 4);
        issue(0, 2'd2, 1, 64'h44, 0, 64'h00000000F0E1D2C3, 0, 2, 4);

        wa = wrCntA; wb = wrCntB;
`ifdef MISALIGN_TRAP_EN
        issue(0, 2'd2, 0, 64'h42, 0, 64'd0, 1, 1, 1);
`else
        issue(0, 2'd2, 0, 64'h42, 0, 64'hFFFFFFFFB4A59687, 0, 2, 4);
`endif
        chk("mis_noWrA", 64'(wrCntA - wa), 64'd0);
        chk("mis_noWrB", 64'(wrCntB - wb), 64'd0);

        wa = wrCntA; wb = wrCntB;
        issue(1, 2'd0, 0, 64'h43, 64'hAA, 64'd0, 0, 3, 5);
        chk("sb_wrCntA", 64'(wrCntA - wa), 64'd1);
        chk("sb_wrCntB", 64'(wrCntB - wb), 64'd1);
        chk("sb_addrA", lastAddrA, 64'h40);
        chk("sb_wdataA", lastWdA, 64'hF0E1D2C3AAA59687);
        chk("sb_wdataB", lastWdB, 64'hF0E1D2C3AAA59687);
        chk("sb_memA", memA[8], 64'hF0E1D2C3AAA59687);

        issue(1, 2'd3, 0, 64'h48, 64'h0123456789ABCDEF, 64'd0, 0, 2, 2);
        issue(1, 2'd1, 0, 64'h4A, 64'h000000000000BEEF, 64'd0, 0, 3, 5);
        issue(0, 2'd3, 0, 64'h48, 0, 64'h01234567BEEFCDEF, 0, 2, 4);
        repeat (3) @(negedge clk);
        chk("hold_rdataA", rspRdA, 64'h01234567BEEFCDEF);
        chk("hold_rdataB", rspRdB, 64'h01234567BEEFCDEF);

        wa = wrCntA; wb = wrCntB;
        @(negedge clk);
        reqWe = 1; reqSize = 2'd0; reqUns = 0;
        reqAddr = 64'h40; reqWdata = 64'h55;
        validA = 1'b1; validB = 1'b1;
        @(posedge clk);
        #1;
        validA = 1'b0; validB = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstmid_readyA", 64'(readyA), 64'd1);
        chk("rstmid_readyB", 64'(readyB), 64'd1);
        chk("rstmid_memWrA", 64'(memWrA), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("rstpost_readyA", 64'(readyA), 64'd1);
        chk("rstpost_wrA", 64'(wrCntA - wa), 64'd0);
        chk("rstpost_wrB", 64'(wrCntB - wb), 64'd0);
        chk("rstpost_memA", memA[8], 64'hF0E1D2C3AAA59687);
        chk("rstpost_memB", memB[8], 64'hF0E1D2C3AAA59687);

        s[0] = '{1, 2'd0, 0, 64'h50, 64'h11, 64'd0, 3};
        s[1] = '{0, 2'd0, 0, 64'h50, 64'd0, 64'h11, 2};
        s[2] = '{1, 2'd1, 0, 64'h52, 64'h8001, 64'd0, 3};
        s[3] = '{0, 2'd1, 0, 64'h52, 64'd0, 64'hFFFFFFFFFFFF8001, 2};
        s[4] = '{0, 2'd3, 0, 64'h50, 64'd0, 64'h0000000080010011, 2};
        @(negedge clk);
        reqWe = s[0].we; reqSize = s[0].sz; reqUns = s[0].uns;
        reqAddr = s[0].addr; reqWdata = s[0].wd;
        validA = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 20; k++) begin
                if (readyA) break;
                @(negedge clk);
            end
            @(posedge clk);
            e.rd = s[i].rd; e.err = 0; e.lat = s[i].lat; e.tAcc = $time;
            qA.push_back(e);
            #1;
            if (i < 4) begin
                reqWe = s[i+1].we; reqSize = s[i+1].sz;
                reqUns = s[i+1].uns; reqAddr = s[i+1].addr;
                reqWdata = s[i+1].wd;
            end else begin
                validA = 1'b0;
            end
            @(negedge clk);
            chk("stream_busyReady", 64'(readyA), 64'd0);
        end
        waitDone();
        repeat (4) @(negedge clk);
        chk("stream_memA", memA[10], 64'h0000000080010011);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
